// File: rtl/sd_cmd_sequencer_if.sv
// Command/response bundle between the SD host register block, the command
// sequencer and the CMD-line physical-layer controller.
// The sequencer sits on the slave modport; whoever drives requests and plays
// the physical layer (register block plus PHY, or a bench) uses master.
interface sd_cmd_sequencer_if;
  // host register block side
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         cmd_abort;
  logic         cmd_busy;
  logic         cmd_done;
  logic [4:0]   error_status;
  logic [127:0] resp_data;

  // physical layer side
  logic [47:0]  phy_frame;
  logic         phy_strobe;
  logic         phy_ack;
  logic         phy_idle;
  logic         phy_no_response;
  logic         phy_strobe_in;
  logic         phy_ack_in;
  logic [127:0] phy_response;
  logic         phy_timeout;

  modport slave (
    input  cmd_start, cmd_index, cmd_argument, resp_type, cmd_abort,
    input  phy_strobe_in, phy_ack_in, phy_response, phy_timeout,
    output cmd_busy, cmd_done, error_status, resp_data,
    output phy_frame, phy_strobe, phy_ack, phy_idle, phy_no_response
  );

  modport master (
    output cmd_start, cmd_index, cmd_argument, resp_type, cmd_abort,
    output phy_strobe_in, phy_ack_in, phy_response, phy_timeout,
    input  cmd_busy, cmd_done, error_status, resp_data,
    input  phy_frame, phy_strobe, phy_ack, phy_idle, phy_no_response
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: builds the 48-bit CMD frame with a bit-serial CRC7,
// hands it to the physical layer over a strobe/ack handshake, captures the
// response, validates CRC/index/end bit and retries on a bare CRC failure.
// A watchdog over the response wait and an external abort both route through
// a two-cycle ABORT state that forces the physical layer idle.
module sd_cmd_sequencer #(
  parameter int unsigned RETRY_MAX = 2,
  parameter int unsigned WATCHDOG  = 1024
) (
  input logic               sd_clock,
  input logic               reset,
  sd_cmd_sequencer_if.slave bus
);

  localparam int unsigned WD_W = $clog2(WATCHDOG + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);
  localparam int unsigned RT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_BUILD, S_ISSUE, S_WAIT_RESP, S_WAIT_ACK, S_CHECK, S_ABORT, S_DONE
  } state_t;

  state_t          state;
  logic [5:0]      lat_index;
  logic [31:0]     lat_arg;
  logic            lat_long;
  logic [6:0]      crc;
  logic [6:0]      bit_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [RT_W-1:0] retry_cnt;

  logic            busy_q;
  logic            done_q;
  logic [4:0]      err_q;
  logic [127:0]    resp_data_q;
  logic [47:0]     frame_q;
  logic            strobe_q;
  logic            ack_q;
  logic            idle_q;
  logic            no_resp_q;

  logic [39:0]     cmd_bits;
  logic [6:0]      check_top;
  logic            crc_in_bit;
  logic [6:0]      crc_next;
  logic            last_build;
  logic            last_check;
  logic            crc_err;
  logic            idx_err;
  logic            end_err;
  logic            abort_req;
  logic            wd_expire;

  // Command header the CRC covers: start bit 0, transmission bit 1, index, argument.
  assign cmd_bits  = {2'b01, lat_index, lat_arg};
  assign check_top = lat_long ? 7'd127 : 7'd47;

  // Select the bit fed to the serial CRC: command header in BUILD, response in CHECK.
  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    crc_in_bit = 1'b0;
    if (state == S_BUILD) begin
      crc_in_bit = cmd_bits[6'd39 - bit_cnt[5:0]];
    end else if (state == S_CHECK) begin
      crc_in_bit = resp_data_q[check_top - bit_cnt];
    end
  end

  // x^7 + x^3 + 1, MSB first, one bit per cycle.
  assign crc_next   = {crc[5:0], 1'b0} ^ ({7{crc_in_bit ^ crc[6]}} & 7'h09);
  assign last_build = (bit_cnt == 7'd39);
  assign last_check = lat_long ? (bit_cnt == 7'd119) : (bit_cnt == 7'd39);

  // Response checks, meaningful on the last CHECK cycle once crc_next holds the full CRC.
  assign crc_err = (crc_next != resp_data_q[7:1]);
  assign idx_err = !lat_long && (resp_data_q[45:40] != lat_index);
  assign end_err = !resp_data_q[0];

  // Abort is honoured in every working state; ABORT and DONE are already winding down.
  assign abort_req = bus.cmd_abort &&
                     (state inside {S_BUILD, S_ISSUE, S_WAIT_RESP, S_WAIT_ACK, S_CHECK});
  assign wd_expire = (state inside {S_WAIT_RESP, S_WAIT_ACK}) && (wd_cnt == WD_LAST);

  // Sequencer FSM with all datapath registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the reset is asynchronous, so outputs drop the moment reset asserts, not at the next edge.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      lat_index   <= '0;
      lat_arg     <= '0;
      lat_long    <= 1'b0;
      crc         <= '0;
      bit_cnt     <= '0;
      wd_cnt      <= '0;
      retry_cnt   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      resp_data_q <= '0;
      frame_q     <= '0;
      strobe_q    <= 1'b0;
      ack_q       <= 1'b0;
      idle_q      <= 1'b0;
      no_resp_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_req || wd_expire) begin
        // Abort beats a same-cycle response strobe, so nothing is latched here.
        if (abort_req) err_q[4] <= 1'b1;
        if (wd_expire) err_q[3] <= 1'b1;
        strobe_q <= 1'b0;
        ack_q    <= 1'b0;
        idle_q   <= 1'b1;
        bit_cnt  <= '0;
        state    <= S_ABORT;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cmd_start) begin
              lat_index   <= bus.cmd_index;
              lat_arg     <= bus.cmd_argument;
              lat_long    <= (bus.resp_type == 2'b10);
              no_resp_q   <= (bus.resp_type == 2'b00);
              err_q       <= '0;
              resp_data_q <= '0;
              crc         <= '0;
              bit_cnt     <= '0;
              busy_q      <= 1'b1;
              state       <= S_BUILD;
            end
          end
          S_BUILD: begin
            crc <= crc_next;
            if (last_build) begin
              frame_q  <= {cmd_bits, crc_next, 1'b1};
              bit_cnt  <= '0;
              strobe_q <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          S_ISSUE: begin
            strobe_q <= 1'b0;
            wd_cnt   <= '0;
            state    <= S_WAIT_RESP;
          end
          S_WAIT_RESP: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (bus.phy_strobe_in) begin
              resp_data_q <= bus.phy_response;
              err_q[3]    <= bus.phy_timeout;
              ack_q       <= 1'b1;
              state       <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (bus.phy_ack_in) begin
              ack_q <= 1'b0;
              if (no_resp_q || err_q[3]) begin
                state <= S_DONE;
              end else begin
                crc     <= '0;
                bit_cnt <= '0;
                state   <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            crc <= crc_next;
            if (last_check) begin
              if (crc_err && !idx_err && !end_err && (retry_cnt < RT_MAX)) begin
                retry_cnt <= retry_cnt + 1'b1;
                err_q     <= '0;
                strobe_q  <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                err_q[2:0] <= {crc_err, idx_err, end_err};
                state      <= S_DONE;
              end
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          S_ABORT: begin
            if (bit_cnt == 7'd1) begin
              idle_q <= 1'b0;
              state  <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          S_DONE: begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            retry_cnt <= '0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_busy        = busy_q;
  assign bus.cmd_done        = done_q;
  assign bus.error_status    = err_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.phy_frame       = frame_q;
  assign bus.phy_strobe      = strobe_q;
  assign bus.phy_ack         = ack_q;
  assign bus.phy_idle        = idle_q;
  assign bus.phy_no_response = no_resp_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer. The bench plays both the register
// block and the physical layer; expected completions go into a scoreboard
// queue when a command is issued and are compared when cmd_done pulses.
module tb_sd_cmd_sequencer;
  localparam int RETRY_MAX = 2;
  localparam int WATCHDOG  = 1024;

  logic sd_clock = 1'b0;
  logic reset    = 1'b0;
  always #5 sd_clock = ~sd_clock;

  sd_cmd_sequencer_if bus ();

  sd_cmd_sequencer #(.RETRY_MAX(RETRY_MAX), .WATCHDOG(WATCHDOG)) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [4:0]   err;
    logic [127:0] resp;
    int           strobes;
    logic [47:0]  frame;
    logic         no_resp;
  } exp_t;

  exp_t sb[$];
  int   strobe_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC7 over the low nbits of data, MSB first.
  function automatic logic [6:0] crc7(input logic [127:0] data, input int nbits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] b;
    b = {2'b01, idx, arg};
    return {b, crc7(128'(b), 40), 1'b1};
  endfunction

  function automatic logic [127:0] short_resp(input logic [39:0] body, input logic bad_crc,
                                              input logic end_bit);
    logic [6:0] c;
    c = crc7(128'(body), 40);
    if (bad_crc) c = ~c;
    return {80'h0, body, c, end_bit};
  endfunction

  task automatic push_exp(input logic [4:0] err, input logic [127:0] resp, input int strobes,
                          input logic [47:0] frame, input logic no_resp);
    exp_t e;
    e.err = err; e.resp = resp; e.strobes = strobes; e.frame = frame; e.no_resp = no_resp;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: frame checked at every strobe, completion checked at cmd_done.
  always @(negedge sd_clock) begin
    exp_t e;
    if (bus.phy_strobe) begin
      strobe_cnt++;
      if (sb.size() != 0) begin
        check("phy_frame", 128'(bus.phy_frame), 128'(sb[0].frame));
        check("phy_no_response", 128'(bus.phy_no_response), 128'(sb[0].no_resp));
      end
    end
    if (bus.cmd_done) begin
      check("done_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("error_status", 128'(bus.error_status), 128'(e.err));
        check("resp_data", bus.resp_data, e.resp);
        check("strobe_count", 128'(strobe_cnt), 128'(e.strobes));
        check("busy_at_done", 128'(bus.cmd_busy), 128'(0));
      end
      strobe_cnt = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sd_clock);
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    bus.cmd_index    = idx;
    bus.cmd_argument = arg;
    bus.resp_type    = rt;
    bus.cmd_start    = 1'b1;
    tick();
    bus.cmd_start    = 1'b0;
  endtask

  task automatic wait_strobe(output int lat);
    lat = 0;
    while (!bus.phy_strobe && lat < 2000) begin
      tick();
      lat++;
    end
    check("strobe_seen", 128'(bus.phy_strobe), 128'(1));
  endtask

  // Physical-layer model: response strobe two cycles after the request, ack two cycles later.
  task automatic respond(input logic [127:0] resp, input logic tflag);
    tick(2);
    bus.phy_response  = resp;
    bus.phy_timeout   = tflag;
    bus.phy_strobe_in = 1'b1;
    tick();
    bus.phy_strobe_in = 1'b0;
    bus.phy_timeout   = 1'b0;
    check("phy_ack_raised", 128'(bus.phy_ack), 128'(1));
    tick(2);
    check("phy_ack_held", 128'(bus.phy_ack), 128'(1));
    bus.phy_ack_in = 1'b1;
    tick();
    bus.phy_ack_in = 1'b0;
    check("phy_ack_dropped", 128'(bus.phy_ack), 128'(0));
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.cmd_done && lat < 4000) begin
      tick();
      lat++;
    end
    check("done_seen", 128'(bus.cmd_done), 128'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "global timeout");
  end

  initial begin
    int           lat;
    logic [127:0] r_good, r_bad, r_idx, r_long, r_tmo, tmp;
    logic [119:0] lbody;
    logic [31:0]  larg;

    bus.cmd_start = 1'b0; bus.cmd_index = '0; bus.cmd_argument = '0; bus.resp_type = '0;
    bus.cmd_abort = 1'b0; bus.phy_strobe_in = 1'b0; bus.phy_ack_in = 1'b0;
    bus.phy_response = '0; bus.phy_timeout = 1'b0;

    // Reset state
    tick(3);
    check("rst_busy", 128'(bus.cmd_busy), 128'(0));
    check("rst_done", 128'(bus.cmd_done), 128'(0));
    check("rst_error_status", 128'(bus.error_status), 128'(0));
    check("rst_resp_data", bus.resp_data, 128'(0));
    check("rst_phy_frame", 128'(bus.phy_frame), 128'(0));
    check("rst_phy_strobe", 128'(bus.phy_strobe), 128'(0));
    check("rst_phy_ack", 128'(bus.phy_ack), 128'(0));
    check("rst_phy_idle", 128'(bus.phy_idle), 128'(0));
    check("rst_phy_no_response", 128'(bus.phy_no_response), 128'(0));
    reset = 1'b1;
    tick(2);

    // CMD0, no response: known frame, strobe in cycle 41, done 2 cycles after ack
    push_exp(5'b00000, 128'(0), 1, 48'h400000000095, 1'b1);
    start_cmd(6'd0, 32'h0, 2'b00);
    wait_strobe(lat);
    check("strobe_latency", 128'(lat + 1), 128'(41));
    check("busy_in_flight", 128'(bus.cmd_busy), 128'(1));
    respond(128'(0), 1'b0);
    wait_done(lat);
    check("done_latency_none", 128'(lat), 128'(2));
    tick();

    // CMD17, good short response: CHECK adds 40 cycles
    r_good = short_resp(40'h1100000900, 1'b0, 1'b1);
    push_exp(5'b00000, r_good, 1, make_frame(6'd17, 32'h0), 1'b0);
    start_cmd(6'd17, 32'h0, 2'b01);
    wait_strobe(lat);
    respond(r_good, 1'b0);
    wait_done(lat);
    check("done_latency_short", 128'(lat), 128'(42));
    tick();

    // Response CRC always wrong: two re-issues, then crc error
    r_bad = short_resp(40'h1100000900, 1'b1, 1'b1);
    push_exp(5'b00100, r_bad, RETRY_MAX + 1, make_frame(6'd17, 32'h0), 1'b0);
    start_cmd(6'd17, 32'h0, 2'b01);
    for (int k = 0; k <= RETRY_MAX; k++) begin
      wait_strobe(lat);
      respond(r_bad, 1'b0);
    end
    wait_done(lat);
    tick();

    // Wrong index and end bit 0 with a valid CRC: no retry
    r_idx = short_resp(40'h1200000900, 1'b0, 1'b0);
    push_exp(5'b00011, r_idx, 1, make_frame(6'd17, 32'h0), 1'b0);
    start_cmd(6'd17, 32'h0, 2'b01);
    wait_strobe(lat);
    respond(r_idx, 1'b0);
    wait_done(lat);
    tick();

    // cmd_abort in IDLE is ignored; status and data stay held
    bus.cmd_abort = 1'b1;
    tick(3);
    bus.cmd_abort = 1'b0;
    check("idle_abort_busy", 128'(bus.cmd_busy), 128'(0));
    check("idle_abort_phy_idle", 128'(bus.phy_idle), 128'(0));
    check("held_error_status", 128'(bus.error_status), 128'(5'b00011));
    check("held_resp_data", bus.resp_data, r_idx);

    // Long response: 120-bit CRC, CHECK adds 120 cycles
    tmp    = {$urandom(), $urandom(), $urandom(), $urandom()};
    lbody  = tmp[119:0];
    r_long = {lbody, crc7(128'(lbody), 120), 1'b1};
    larg   = $urandom();
    push_exp(5'b00000, r_long, 1, make_frame(6'd2, larg), 1'b0);
    start_cmd(6'd2, larg, 2'b10);
    wait_strobe(lat);
    respond(r_long, 1'b0);
    wait_done(lat);
    check("done_latency_long", 128'(lat), 128'(122));
    tick();

    // resp_type 11 behaves as a short response
    r_good = short_resp(40'h11DEAD0900, 1'b0, 1'b1);
    push_exp(5'b00000, r_good, 1, make_frame(6'd17, 32'h1234), 1'b0);
    start_cmd(6'd17, 32'h1234, 2'b11);
    wait_strobe(lat);
    respond(r_good, 1'b0);
    wait_done(lat);
    check("done_latency_type11", 128'(lat), 128'(42));
    tick();

    // Physical-layer timeout flag: straight to DONE, no CHECK
    r_tmo = short_resp(40'h1100000000, 1'b0, 1'b1);
    push_exp(5'b01000, r_tmo, 1, make_frame(6'd17, 32'h55), 1'b0);
    start_cmd(6'd17, 32'h55, 2'b01);
    wait_strobe(lat);
    respond(r_tmo, 1'b1);
    wait_done(lat);
    check("done_latency_timeout", 128'(lat), 128'(2));
    tick();

    // Response never arrives: watchdog abort, phy_idle for two cycles
    push_exp(5'b01000, 128'(0), 1, make_frame(6'd8, 32'hA5A50001), 1'b0);
    start_cmd(6'd8, 32'hA5A50001, 2'b01);
    wait_strobe(lat);
    lat = 0;
    while (!bus.phy_idle && lat < 3000) begin
      tick();
      lat++;
    end
    check("watchdog_latency", 128'(lat), 128'(WATCHDOG + 1));
    tick();
    check("watchdog_idle_2nd", 128'(bus.phy_idle), 128'(1));
    tick();
    check("watchdog_idle_off", 128'(bus.phy_idle), 128'(0));
    wait_done(lat);
    tick();

    // cmd_abort in BUILD cycle 10: no strobe, abort status
    push_exp(5'b10000, 128'(0), 0, 48'h0, 1'b0);
    start_cmd(6'd3, 32'h1, 2'b01);
    tick(9);
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    check("abort_phy_idle", 128'(bus.phy_idle), 128'(1));
    wait_done(lat);
    tick();

    // Normal command afterwards; a cmd_start while busy must not disturb it
    r_good = short_resp(40'h1100000900, 1'b0, 1'b1);
    push_exp(5'b00000, r_good, 1, make_frame(6'd17, 32'hDEADBEEF), 1'b0);
    start_cmd(6'd17, 32'hDEADBEEF, 2'b01);
    tick(5);
    bus.cmd_index    = 6'd5;
    bus.cmd_argument = 32'h0;
    bus.cmd_start    = 1'b1;
    tick();
    bus.cmd_start    = 1'b0;
    wait_strobe(lat);
    respond(r_good, 1'b0);
    wait_done(lat);
    tick();

    // Abort together with the response strobe: abort wins, nothing latched
    push_exp(5'b10000, 128'(0), 1, make_frame(6'd17, 32'h0), 1'b0);
    start_cmd(6'd17, 32'h0, 2'b01);
    wait_strobe(lat);
    tick(2);
    bus.phy_response  = r_good;
    bus.phy_strobe_in = 1'b1;
    bus.cmd_abort     = 1'b1;
    tick();
    bus.phy_strobe_in = 1'b0;
    bus.cmd_abort     = 1'b0;
    check("abort_vs_resp_ack", 128'(bus.phy_ack), 128'(0));
    check("abort_vs_resp_idle", 128'(bus.phy_idle), 128'(1));
    wait_done(lat);
    tick();

    // Reset mid-operation: outputs clear immediately
    start_cmd(6'd17, 32'h0, 2'b01);
    wait_strobe(lat);
    tick(3);
    reset = 1'b0;
    #1;
    check("midrst_busy", 128'(bus.cmd_busy), 128'(0));
    check("midrst_phy_frame", 128'(bus.phy_frame), 128'(0));
    check("midrst_phy_idle", 128'(bus.phy_idle), 128'(0));
    check("midrst_no_response", 128'(bus.phy_no_response), 128'(0));
    sb.delete();
    strobe_cnt = 0;
    tick(2);
    reset = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Command-level sequencer placed between the SD host register block and the CMD-line physical-layer controller. It accepts a command request (index, argument, response type) and builds the 48-bit CMD frame with a serially computed CRC7. It runs the strobe/ack handshake with the physical layer, then captures and validates the response. Completion, response data and a per-cause error status go back to the register block, with automatic retry on response CRC failure.

## Interface
- RETRY_MAX, 2: re-issues allowed after a response CRC error (0 = no retry).
- WATCHDOG, 1024: sd_clock cycles allowed in WAIT_RESP plus WAIT_ACK before a forced abort.
- sd_clock  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle request; sampled only in IDLE.
- cmd_index  in  6  command index; sampled with cmd_start.
- cmd_argument  in  32  argument; sampled with cmd_start.
- resp_type  in  2  00 none, 01 short (48-bit), 10 long (136-bit), 11 treated as 01.
- cmd_abort  in  1  abort request; level-sampled.
- cmd_busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle completion pulse.
- error_status  out  5  {abort, timeout, crc, index, end_bit}; valid with cmd_done, held until next cmd_start.
- resp_data  out  128  captured response; held until next cmd_start.
- phy_frame  out  48  {0,1,index,argument,crc7,1} to the P-S wrapper; stable from ISSUE until DONE.
- phy_strobe  out  1  service request to the physical layer.
- phy_ack  out  1  acknowledge to the physical layer.
- phy_idle  out  1  force the physical layer to idle.
- phy_no_response  out  1  equals (resp_type==00) of the latched command.
- phy_strobe_in  in  1  physical layer "response ready" strobe.
- phy_ack_in  in  1  physical layer ack.
- phy_response  in  128  physical layer received frame.
- phy_timeout  in  1  physical layer command timeout flag.

## Operation
- Reset: all outputs 0. State IDLE, counters 0, retry count 0.
- IDLE: on cmd_start, latch index/argument/resp_type, clear error_status and resp_data, then go to BUILD.
- BUILD: serial CRC7 (x^7+x^3+1, init 0) over the 40 bits {0,1,index,argument}, MSB first, one bit per cycle, 40 cycles. Then load phy_frame and go to ISSUE.
- ISSUE: phy_strobe=1 for exactly one cycle, then WAIT_RESP.
- WAIT_RESP: wait for phy_strobe_in=1. On that cycle, latch phy_response into resp_data and phy_timeout into error_status[3], then go to WAIT_ACK.
- WAIT_ACK: hold phy_ack=1 until phy_ack_in=1 is sampled; deassert the next cycle.
  - resp_type 00 or timeout set: go to DONE.
  - Otherwise: go to CHECK.
- CHECK, short response (resp_data[47:0]):
  - Recompute CRC7 serially over bits [47:8], 40 cycles.
  - crc error = mismatch with [7:1].
  - index error = [45:40] != latched index.
  - end_bit error = [0]==0.
- CHECK, long response: recompute CRC7 over [127:8], 120 cycles. Check crc and end bit; no index check.
- After CHECK:
  - crc error only, retry count < RETRY_MAX: increment retry count, clear errors, return to ISSUE.
  - Otherwise: go to DONE.
- DONE: cmd_done=1 for one cycle; return to IDLE. The retry count clears on entry to IDLE.
- Watchdog: counts cycles in WAIT_RESP plus WAIT_ACK. Reaching WATCHDOG sets error_status[3] and enters ABORT.
- cmd_abort=1 in any non-IDLE state: set error_status[4] and enter ABORT.
- ABORT: phy_idle=1 for 2 cycles, phy_strobe/phy_ack=0, then DONE.
- cmd_abort in IDLE is ignored.

## Timing
- Registered outputs; no combinational input-to-output path.
- cmd_start in cycle 0 → BUILD in cycles 1-40 → phy_frame valid and phy_strobe high in cycle 41.
- No-response command: cmd_done follows 2 cycles after phy_ack_in is sampled.
- Short response: CHECK adds 40 cycles; long response adds 120 cycles.
- Simultaneous cmd_abort and phy_strobe_in: abort wins; the response is not latched.
- Simultaneous watchdog expiry and cmd_abort: both bits 4 and 3 are set.
- cmd_start while busy: ignored; no queueing.
- Reset mid-operation: outputs go to 0 immediately. phy_idle is not pulsed; the physical layer shares this reset.

## Test plan
- Index 0, argument 0, resp_type 00 → phy_frame 0x400000000095, phy_no_response=1, cmd_done with error_status 0.
- Index 17, argument 0, resp_type 01, phy_response[47:0]=0x110000090000 with the correct CRC → error_status 0, resp_data[47:0] matches.
- Same command with response CRC bits flipped → 2 re-issues (3 phy_strobe pulses total), final error_status 00100.
- Short response with index 18 against cmd_index 17 and end bit 0 → no retry, error_status 00011.
- phy_strobe_in never arrives → after 1024 cycles phy_idle is high for 2 cycles, then cmd_done with error_status 01000.
- cmd_abort asserted in BUILD cycle 10 → ABORT, no phy_strobe pulse, error_status 10000; a later cmd_start then completes normally.
